axi2wb: RTL and testbench

Bridge that makes the FIR's AXI-side protocols drive a Wishbone bus: an AXI-lite slave and an AXI-stream slave on one side, a single Wishbone master on the other. It lets AXI-side test masters and DMA-style producers reach Wishbone peripherals, such as the user project's wb2axi-fronted FIR, through the same 12-bit register/stream address map. It runs one outstanding Wishbone cycle at a time, with fixed-priority arbitration between AXI-lite writes, AXI-lite reads and stream beats.

---
 rtl/axi2wb_if.sv | 44 ++++
 rtl/axi2wb.sv | 135 +++++++++++++
 tb/tb_axi2wb.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2wb_if.sv
`default_nettype none
// ============================================================================
// Module   : axi2wb_if
// Brief    : AXI-lite / AXI-stream slave and Wishbone master bundle for axi2wb.
// Revision : 1.0  initial release
// ============================================================================
interface axi2wb_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]             wbm_sel_o;
  logic [31:0]            wbm_adr_o;
  logic [pDATA_WIDTH-1:0] wbm_dat_o;
  logic [pDATA_WIDTH-1:0] wbm_dat_i;
  logic                   wbm_ack_i;
  logic                   wb_err;

  // Bridge side: AXI slave toward the producers, Wishbone master toward the bus
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, wbm_dat_i, wbm_ack_i,
    output awready, wready, arready, rvalid, rdata, ss_tready,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, wb_err
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, wbm_dat_i, wbm_ack_i,
    input  awready, wready, arready, rvalid, rdata, ss_tready,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/axi2wb.sv
`default_nettype none
// ============================================================================
// Module   : axi2wb
// Brief    : AXI-lite + AXI-stream slave to single-outstanding Wishbone master.
//            Optional ack timeout enabled by defining AXI2WB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module axi2wb #(
  parameter int                     pADDR_WIDTH   = 12,
  parameter int                     pDATA_WIDTH   = 32,
  parameter logic [31:0]            pWB_BASE      = 32'h3000_0000,
  parameter logic [pADDR_WIDTH-1:0] pSS_ADDR      = 'h080,
  parameter logic [pADDR_WIDTH-1:0] pSS_LAST_ADDR = 'h084,
  parameter int                     pTIMEOUT      = 255
) (
  input  wire logic axis_clk,
  input  wire logic axis_rst_n,
  axi2wb_if.slave   bus
);

  if (pTIMEOUT < 1 || pDATA_WIDTH != 32 || pADDR_WIDTH > 32) begin : g_param_check
    $error("axi2wb: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_WR   = 2'd1,
    WB_RD   = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  localparam logic [pDATA_WIDTH-1:0] c_TIMEOUT_DATA = pDATA_WIDTH'(32'hDEAD_BEEF);

  state_t                 r_state, w_next_state;
  logic [31:0]            r_adr;
  logic [pDATA_WIDTH-1:0] r_dat;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic                   r_we;
  logic                   w_idle, w_wr_pair, w_take_wr, w_take_rd, w_take_ss;
  logic                   w_cyc, w_timeout;

  // Readies are gated by reset so nothing is acknowledged while held in reset
  assign w_idle    = (r_state == IDLE) & axis_rst_n;
  assign w_wr_pair = bus.awvalid & bus.wvalid;
  assign w_take_wr = w_idle & w_wr_pair;
  assign w_take_rd = w_idle & ~w_wr_pair & bus.arvalid;
  assign w_take_ss = w_idle & ~w_wr_pair & ~bus.arvalid & bus.ss_tvalid;
  assign w_cyc     = (r_state == WB_WR) | (r_state == WB_RD);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_wr || w_take_ss) w_next_state = WB_WR;
        else if (w_take_rd)         w_next_state = WB_RD;
      end
      WB_WR:   if (bus.wbm_ack_i || w_timeout) w_next_state = IDLE;
      WB_RD:   if (bus.wbm_ack_i || w_timeout) w_next_state = RD_RESP;
      RD_RESP: if (bus.rready)                 w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_take_wr) begin
        r_adr <= pWB_BASE | 32'(bus.awaddr);
        r_dat <= bus.wdata;
        r_we  <= 1'b1;
      end else if (w_take_rd) begin
        r_adr <= pWB_BASE | 32'(bus.araddr);
        r_we  <= 1'b0;
      end else if (w_take_ss) begin
        r_adr <= pWB_BASE | 32'(bus.ss_tlast ? pSS_LAST_ADDR : pSS_ADDR);
        r_dat <= bus.ss_tdata;
        r_we  <= 1'b1;
      end
      if (r_state == WB_RD) begin
        if (bus.wbm_ack_i)  r_rdata <= bus.wbm_dat_i;
        else if (w_timeout) r_rdata <= c_TIMEOUT_DATA;
      end
    end
  end

`ifdef AXI2WB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(pTIMEOUT + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_err;

  // Fires during the pTIMEOUT-th strobe cycle that still has no ack
  assign w_timeout = w_cyc & ~bus.wbm_ack_i & (r_to_cnt == c_TO_W'(pTIMEOUT - 1));

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_cyc && !bus.wbm_ack_i && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
      else                                       r_to_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.wb_err = r_err;
`else
  assign w_timeout  = 1'b0;
  assign bus.wb_err = 1'b0;
`endif

  assign bus.awready   = w_take_wr;
  assign bus.wready    = w_take_wr;
  assign bus.arready   = w_take_rd;
  assign bus.ss_tready = w_take_ss;
  assign bus.rvalid    = (r_state == RD_RESP);
  assign bus.rdata     = r_rdata;
  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = w_cyc;
  assign bus.wbm_we_o  = w_cyc & r_we;
  assign bus.wbm_sel_o = 4'hF;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_axi2wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi2wb
// Brief    : Randomized self-checking bench for axi2wb with a Wishbone memory
//            slave and an address-map reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi2wb;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi2wb_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();
  axi2wb dut (.axis_clk(clk), .axis_rst_n(rst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: what every Wishbone address should hold
  logic [31:0] exp_mem [logic [31:0]];
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Wishbone memory slave with programmable wait states
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; int len; } txn_t;
  txn_t        act_q[$];
  txn_t        s_t;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] first_adr, first_dat;
  int          wb_wait = 0, slv_cnt = 0, stb_cycles = 0, viol = 0;
  bit          slv_hang = 0, stray_en = 0, acked = 0;

  always @(negedge clk) begin
    if (acked) check("cyc_drop", bus.wbm_cyc_o, 0);
    acked         = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = $urandom;
    if (bus.wbm_cyc_o !== bus.wbm_stb_o || bus.wbm_sel_o !== 4'hF) viol++;
    if (bus.wbm_cyc_o && (bus.awready | bus.wready | bus.arready | bus.ss_tready)) viol++;
    if (bus.wbm_cyc_o === 1'b1) begin
      if (slv_cnt == 0) begin
        first_adr = bus.wbm_adr_o;
        first_dat = bus.wbm_dat_o;
      end else if (bus.wbm_adr_o !== first_adr || (bus.wbm_we_o && bus.wbm_dat_o !== first_dat)) viol++;
      slv_cnt++;
      stb_cycles++;
      if (!slv_hang && slv_cnt > wb_wait) begin
        bus.wbm_ack_i = 1'b1;
        acked         = 1;
        s_t.we  = bus.wbm_we_o;
        s_t.adr = bus.wbm_adr_o;
        s_t.len = slv_cnt;
        if (bus.wbm_we_o) begin
          slv_mem[bus.wbm_adr_o] = bus.wbm_dat_o;
          s_t.dat = bus.wbm_dat_o;
        end else begin
          s_t.dat = slv_mem.exists(bus.wbm_adr_o) ? slv_mem[bus.wbm_adr_o]
                                                  : (bus.wbm_adr_o ^ 32'hA5A5_5A5A);
          bus.wbm_dat_i = s_t.dat;
        end
        act_q.push_back(s_t);
        slv_cnt = 0;
      end
    end else begin
      slv_cnt = 0;
      if (stray_en && $urandom_range(0, 3) == 0) bus.wbm_ack_i = 1'b1;
    end
  end

  task automatic wait_txn(output txn_t t, output bit ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (act_q.size() > 0) begin
        t  = act_q.pop_front();
        ok = 1;
        return;
      end
    end
    check("txn_timeout", 0, 1);
  endtask

  task automatic lite_write(input logic [11:0] a, input logic [31:0] d, input int wt);
    txn_t t; bit ok; int n;
    wb_wait = wt;
    @(posedge clk); #1;
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = a; bus.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 1000);
    check("wr_awready", bus.awready, 1);
    check("wr_wready", bus.wready, 1);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    exp_mem[BASE | 32'(a)] = d;
    wait_txn(t, ok);
    if (ok) begin
      check("wr_we", t.we, 1);
      check("wr_adr", t.adr, BASE | 32'(a));
      check("wr_dat", t.dat, d);
      check("wr_len", t.len, wt + 1);
    end
  endtask

  task automatic lite_read(input logic [11:0] a, input int wt, input int hold);
    txn_t t; bit ok, bad; int n; logic [31:0] e;
    wb_wait = wt;
    bus.rready = 0;
    @(posedge clk); #1;
    bus.arvalid = 1; bus.araddr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 1000);
    check("rd_arready", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 0;
    e = exp_read(BASE | 32'(a));
    wait_txn(t, ok);
    if (ok) begin
      check("rd_we", t.we, 0);
      check("rd_adr", t.adr, BASE | 32'(a));
      check("rd_len", t.len, wt + 1);
    end
    @(negedge clk);
    check("rvalid_at_a1", bus.rvalid, 1);
    check("rdata", bus.rdata, e);
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (bus.rvalid !== 1'b1 || bus.rdata !== e) bad = 1;
    end
    check("rvalid_held", bad, 0);
    @(posedge clk); #1 bus.rready = 1;
    @(posedge clk); #1 bus.rready = 0;
    @(negedge clk);
    check("rvalid_clear", bus.rvalid, 0);
  endtask

  task automatic stream_beat(input logic [31:0] d, input logic last, input int wt);
    txn_t t; bit ok; int n; logic [31:0] ea;
    wb_wait = wt;
    @(posedge clk); #1;
    bus.ss_tvalid = 1; bus.ss_tdata = d; bus.ss_tlast = last;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ss_tready && n < 1000);
    check("ss_tready", bus.ss_tready, 1);
    @(posedge clk); #1;
    bus.ss_tvalid = 0;
    ea = BASE | (last ? 32'h084 : 32'h080);
    exp_mem[ea] = d;
    wait_txn(t, ok);
    if (ok) begin
      check("ss_we", t.we, 1);
      check("ss_adr", t.adr, ea);
      check("ss_dat", t.dat, d);
    end
  endtask

  initial begin
    txn_t t; bit ok, bad; int n; logic [11:0] wa, ra; logic [31:0] wd, sd;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1; bus.ss_tvalid = 1;
    bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0; bus.rready = 0;
    bus.ss_tdata = '0; bus.ss_tlast = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", {bus.awready, bus.wready, bus.arready, bus.ss_tready}, 0);
    check("rst_rvalid_rdata", {31'b0, bus.rvalid} | bus.rdata, 0);
    check("rst_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wb_err}, 0);
    check("rst_adr", bus.wbm_adr_o, 0);
    check("rst_dat", bus.wbm_dat_o, 0);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.ss_tvalid = 0;
    @(posedge clk); #1 rst_n = 1;

    lite_write(12'h010, 32'h0000_000B, 1);
    lite_write(12'h000, 32'h0000_0004, 0);
    lite_read(12'h000, 0, 3);

    for (int i = 1; i <= 64; i++) stream_beat(32'(i), i == 64, $urandom_range(0, 2));

    // Half write pair is skipped in favour of a stream beat
    wb_wait = 0; bad = 0;
    @(posedge clk); #1;
    bus.awvalid = 1; bus.awaddr = 12'h020;
    bus.ss_tvalid = 1; bus.ss_tdata = 32'h1234_5678; bus.ss_tlast = 0;
    n = 0;
    do begin @(negedge clk); n++; if (bus.awready) bad = 1; end while (!bus.ss_tready && n < 100);
    check("half_ss_served", bus.ss_tready, 1);
    @(posedge clk); #1 bus.ss_tvalid = 0;
    exp_mem[BASE | 32'h080] = 32'h1234_5678;
    wait_txn(t, ok);
    if (ok) check("half_ss_adr", t.adr, BASE | 32'h080);
    repeat (3) begin @(negedge clk); if (bus.awready) bad = 1; end
    check("half_no_awready", bad, 0);
    bus.awvalid = 0;

    // All sources at once: write, then read, then stream
    wa = 12'h040; wd = $urandom; ra = 12'h044; sd = $urandom;
    wb_wait = 0; bus.rready = 1;
    @(posedge clk); #1;
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = wa; bus.wdata = wd;
    bus.arvalid = 1; bus.araddr = ra;
    bus.ss_tvalid = 1; bus.ss_tdata = sd; bus.ss_tlast = 1;
    fork
      begin
        for (int k = 0; k < 200 && !bus.awready; k++) @(negedge clk);
        @(posedge clk); #1 begin bus.awvalid = 0; bus.wvalid = 0; end
      end
      begin
        for (int k = 0; k < 200 && !bus.arready; k++) @(negedge clk);
        @(posedge clk); #1 bus.arvalid = 0;
      end
      begin
        for (int k = 0; k < 200 && !bus.ss_tready; k++) @(negedge clk);
        @(posedge clk); #1 bus.ss_tvalid = 0;
      end
    join
    repeat (4) @(posedge clk);
    #1 bus.rready = 0;
    exp_mem[BASE | 32'(wa)] = wd;
    check("prio_count", act_q.size(), 3);
    check("prio_rdata", bus.rdata, exp_read(BASE | 32'(ra)));
    exp_mem[BASE | 32'h084] = sd;
    if (act_q.size() == 3) begin
      check("prio_1st", {31'b0, act_q[0].we} ^ act_q[0].adr, 32'd1 ^ (BASE | 32'(wa)));
      check("prio_2nd", {31'b0, act_q[1].we} ^ act_q[1].adr, BASE | 32'(ra));
      check("prio_3rd", {31'b0, act_q[2].we} ^ act_q[2].adr, 32'd1 ^ (BASE | 32'h084));
      check("prio_3rd_dat", act_q[2].dat, sd);
    end
    act_q.delete();

    // Reset in the middle of a read
    wb_wait = 20;
    @(posedge clk); #1 bus.arvalid = 1; bus.araddr = 12'h010;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 100);
    @(posedge clk); #1 bus.arvalid = 0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_cyc", bus.wbm_cyc_o, 1);
    #2 rst_n = 0;
    #1 check("rst_mid_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    bad = 0;
    repeat (25) begin @(negedge clk); if (bus.rvalid !== 1'b0) bad = 1; end
    check("rst_mid_no_rvalid", bad, 0);
    check("rst_mid_no_txn", act_q.size(), 0);
    lite_read(12'h010, 1, 0);

    // Randomized mix with stray acks between cycles
    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: lite_write(12'($urandom_range(0, 15) * 4), $urandom, $urandom_range(0, 3));
        1: lite_read(12'($urandom_range(0, 33) * 4), $urandom_range(0, 3), $urandom_range(0, 3));
        default: stream_beat($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      endcase
    end
    stray_en = 0;

`ifdef AXI2WB_TIMEOUT_EN
    slv_hang = 1; stb_cycles = 0; bus.rready = 0;
    @(posedge clk); #1 bus.arvalid = 1; bus.araddr = 12'h008;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 100);
    @(posedge clk); #1 bus.arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rvalid && n < 2000);
    check("to_rvalid", bus.rvalid, 1);
    check("to_stb_cycles", stb_cycles, 255);
    check("to_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("to_err", bus.wb_err, 1);
    @(posedge clk); #1 bus.rready = 1;
    @(posedge clk); #1 bus.rready = 0;
    slv_hang = 0;
    repeat (5) @(negedge clk);
    check("to_err_sticky", bus.wb_err, 1);
    #2 rst_n = 0;
    #1 check("to_err_rst", bus.wb_err, 0);
    @(posedge clk); #1 rst_n = 1;
`else
    check("wb_err_tied", bus.wb_err, 0);
`endif

    check("proto_viol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
